mtx_dec_multi_port: RTL and testbench

Parametrised bus-matrix input-side decoder. It routes one AHB input stage to NUM_PORTS output stages, using per-port inclusive address windows, and sends unmapped addresses to an integrated default slave. It muxes the data-phase response back to the input stage. It also captures diagnostics for accesses to unmapped addresses: the first erroring address and a saturating error count.

---
 rtl/mtx_dec_multi_port.sv | 231 +++++++++++++++++++++++
 tb/tb_mtx_dec_multi_port.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtx_dec_multi_port.sv
// -----------------------------------------------------------------------------
// mtx_dec_multi_port
//
// Bus-matrix input-side decoder. It steers one AHB input stage to one of
// NUM_PORTS output stages using per-port inclusive address windows. Any
// address outside every window goes to an integrated default slave, which
// answers NONSEQ/SEQ transfers with a two-cycle ERROR response.
// The data-phase response (HREADYOUT/HRESP/HRDATA/HRUSER) is muxed back from
// whichever target owned the previous address phase.
// The block also records diagnostics for unmapped accesses: the first
// offending address since the last clear, and a saturating count.
//
// Ports:
//   HCLK, HRESET        clock, synchronous active-high reset
//   HREADYS             input-stage HREADY (address phase accepted)
//   sel_dec             HSEL from the input stage
//   decode_addr_dec     HADDR[31:ADDR_LSB]
//   trans_dec           HTRANS
//   active_dec_i        per-port output-stage active flags
//   readyout_dec_i      per-port HREADYOUT
//   resp_dec_i          per-port HRESP (2 bits each)
//   rdata_dec_i         per-port HRDATA (32 bits each)
//   ruser_dec_i         per-port HRUSER (RUSER_W bits each)
//   err_clr             clears err_valid and err_count
//   sel_dec_o           per-port HSEL, one-hot or zero
//   active_dec          active flag of the address-phase target
//   HREADYOUTS, HRESPS, HRUSERS, HRDATAS   muxed data-phase response
//   err_valid, err_addr, err_count         unmapped-access diagnostics
// -----------------------------------------------------------------------------
module mtx_dec_multi_port #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_LSB  = 10,
  parameter int RUSER_W   = 3,
  parameter logic [NUM_PORTS*(32-ADDR_LSB)-1:0] REGION_BASE  = '0,
  parameter logic [NUM_PORTS*(32-ADDR_LSB)-1:0] REGION_LIMIT = '1,
  parameter bit IDLE_HOLD = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  input  logic                           HREADYS,
  input  logic                           sel_dec,
  input  logic [31-ADDR_LSB:0]           decode_addr_dec,
  input  logic [1:0]                     trans_dec,
  input  logic [NUM_PORTS-1:0]           active_dec_i,
  input  logic [NUM_PORTS-1:0]           readyout_dec_i,
  input  logic [2*NUM_PORTS-1:0]         resp_dec_i,
  input  logic [32*NUM_PORTS-1:0]        rdata_dec_i,
  input  logic [RUSER_W*NUM_PORTS-1:0]   ruser_dec_i,
  input  logic                           err_clr,
  output logic [NUM_PORTS-1:0]           sel_dec_o,
  output logic                           active_dec,
  output logic                           HREADYOUTS,
  output logic [1:0]                     HRESPS,
  output logic [RUSER_W-1:0]             HRUSERS,
  output logic [31:0]                    HRDATAS,
  output logic                           err_valid,
  output logic [31-ADDR_LSB:0]           err_addr,
  output logic [CNT_W-1:0]               err_count
);

  localparam int AW = 32 - ADDR_LSB;
  // Select vectors carry one extra entry at index NUM_PORTS for the default slave.
  localparam logic [NUM_PORTS:0] SEL_DEFAULT = {1'b1, {NUM_PORTS{1'b0}}};

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  logic [NUM_PORTS-1:0] match;
  logic [NUM_PORTS:0]   dec_sel;
  logic [NUM_PORTS:0]   addr_sel;
  logic [NUM_PORTS:0]   dsel_reg;
  logic                 found;
  logic                 def_sel;
  logic                 new_access;

  ds_state_t            ds_state_reg, ds_state_next;
  logic                 ds_ready;
  logic [1:0]           ds_resp;

  logic                 err_valid_reg;
  logic [AW-1:0]        err_addr_reg;
  logic [CNT_W-1:0]     err_count_reg;

  // ---------------------------------------------------------------------------
  // Window match. Bounds are checked through the borrow bit of a widened
  // subtraction so that a window starting at zero or ending at all-ones does
  // not degenerate into an always-true constant comparison.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_match
    localparam logic [AW-1:0] BASE  = REGION_BASE[gi*AW +: AW];
    localparam logic [AW-1:0] LIMIT = REGION_LIMIT[gi*AW +: AW];
    logic [AW:0] lo_diff;
    logic [AW:0] hi_diff;
    assign lo_diff    = {1'b0, decode_addr_dec} - {1'b0, BASE};
    assign hi_diff    = {1'b0, LIMIT} - {1'b0, decode_addr_dec};
    assign match[gi]  = ~lo_diff[AW] & ~hi_diff[AW];
  end

  // Lowest matching port wins; no match falls through to the default slave.
  always_comb begin
    dec_sel = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (match[i] && !found) begin
        dec_sel[i] = 1'b1;
        found      = 1'b1;
      end
    end
    if (!found) begin
      dec_sel[NUM_PORTS] = 1'b1;
    end
  end

  // IDLE transfers can keep pointing at the current data-phase owner so the
  // output-stage selects do not toggle for cycles that carry no transfer.
  always_comb begin
    addr_sel = dec_sel;
    if (IDLE_HOLD && (trans_dec == 2'b00)) begin
      addr_sel = dsel_reg;
    end
  end

  assign sel_dec_o  = {NUM_PORTS{sel_dec}} & addr_sel[NUM_PORTS-1:0];
  assign def_sel    = sel_dec & addr_sel[NUM_PORTS];
  assign new_access = def_sel & HREADYS & trans_dec[1];

  always_comb begin
    active_dec = addr_sel[NUM_PORTS];
    for (int i = 0; i < NUM_PORTS; i++) begin
      active_dec = active_dec | (addr_sel[i] & active_dec_i[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Data-phase select: follows the address phase whenever it is accepted.
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dsel_reg <= SEL_DEFAULT;
    end else if (HREADYS) begin
      dsel_reg <= addr_sel;
    end
  end

  // ---------------------------------------------------------------------------
  // Default slave: two-cycle ERROR response (wait, then complete).
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ds_state_reg <= DS_IDLE;
    end else begin
      ds_state_reg <= ds_state_next;
    end
  end

  always_comb begin
    ds_state_next = ds_state_reg;
    ds_ready      = 1'b1;
    ds_resp       = 2'b00;
    case (ds_state_reg)
      DS_IDLE: begin
        if (new_access) begin
          ds_state_next = DS_ERR1;
        end
      end
      DS_ERR1: begin
        ds_ready      = 1'b0;
        ds_resp       = 2'b01;
        ds_state_next = DS_ERR2;
      end
      DS_ERR2: begin
        ds_resp       = 2'b01;
        ds_state_next = new_access ? DS_ERR1 : DS_IDLE;
      end
      default: begin
        ds_state_next = DS_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Data-phase response mux. AND-OR over the one-hot select so an unselected
  // port can never leak X onto the input stage.
  // ---------------------------------------------------------------------------
  always_comb begin
    HREADYOUTS = dsel_reg[NUM_PORTS] & ds_ready;
    HRESPS     = {2{dsel_reg[NUM_PORTS]}} & ds_resp;
    HRDATAS    = '0;
    HRUSERS    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      HREADYOUTS = HREADYOUTS | (dsel_reg[i] & readyout_dec_i[i]);
      HRESPS     = HRESPS  | ({2{dsel_reg[i]}} & resp_dec_i[2*i +: 2]);
      HRDATAS    = HRDATAS | ({32{dsel_reg[i]}} & rdata_dec_i[32*i +: 32]);
      HRUSERS    = HRUSERS | ({RUSER_W{dsel_reg[i]}} & ruser_dec_i[RUSER_W*i +: RUSER_W]);
    end
  end

  // ---------------------------------------------------------------------------
  // Unmapped-access diagnostics. A new error in the same cycle as err_clr
  // starts a fresh record rather than being lost.
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      err_valid_reg <= 1'b0;
      err_addr_reg  <= '0;
      err_count_reg <= '0;
    end else if (new_access) begin
      if (!err_valid_reg || err_clr) begin
        err_addr_reg <= decode_addr_dec;
      end
      err_valid_reg <= 1'b1;
      if (err_clr) begin
        err_count_reg <= CNT_W'(1);
      end else if (!(&err_count_reg)) begin
        err_count_reg <= err_count_reg + CNT_W'(1);
      end
    end else if (err_clr) begin
      err_valid_reg <= 1'b0;
      err_count_reg <= '0;
    end
  end

  assign err_valid = err_valid_reg;
  assign err_addr  = err_addr_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_mtx_dec_multi_port.sv
// -----------------------------------------------------------------------------
// tb_mtx_dec_multi_port
//
// Directed scenarios with literal expectations, followed by a long run of
// randomized traffic. Every cycle the DUT outputs are compared with a
// transaction-level model of the decoder (window lookup, data-phase owner,
// default-slave response phase, error record).
// Map: port0 = 0x000000..0x07FFFF, port1 = 0x080000..0x1FFFFF,
//      0x200000..0x3FFFFF unmapped. IDLE_HOLD = 1, CNT_W = 2.
// -----------------------------------------------------------------------------
module tb_mtx_dec_multi_port;

  localparam int NP  = 2;
  localparam int AW  = 22;
  localparam int RW  = 3;
  localparam int CW  = 2;
  localparam int DEF = NP;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [NP*AW-1:0] RB = {22'h080000, 22'h000000};
  localparam logic [NP*AW-1:0] RL = {22'h1FFFFF, 22'h07FFFF};

  logic              HCLK = 1'b0;
  logic              HRESET;
  logic              HREADYS;
  logic              sel_dec;
  logic [AW-1:0]     decode_addr_dec;
  logic [1:0]        trans_dec;
  logic [NP-1:0]     active_dec_i;
  logic [NP-1:0]     readyout_dec_i;
  logic [2*NP-1:0]   resp_dec_i;
  logic [32*NP-1:0]  rdata_dec_i;
  logic [RW*NP-1:0]  ruser_dec_i;
  logic              err_clr;
  logic [NP-1:0]     sel_dec_o;
  logic              active_dec;
  logic              HREADYOUTS;
  logic [1:0]        HRESPS;
  logic [RW-1:0]     HRUSERS;
  logic [31:0]       HRDATAS;
  logic              err_valid;
  logic [AW-1:0]     err_addr;
  logic [CW-1:0]     err_count;

  mtx_dec_multi_port #(
    .NUM_PORTS    (NP),
    .ADDR_LSB     (10),
    .RUSER_W      (RW),
    .REGION_BASE  (RB),
    .REGION_LIMIT (RL),
    .IDLE_HOLD    (1'b1),
    .CNT_W        (CW)
  ) dut (
    .HCLK            (HCLK),
    .HRESET          (HRESET),
    .HREADYS         (HREADYS),
    .sel_dec         (sel_dec),
    .decode_addr_dec (decode_addr_dec),
    .trans_dec       (trans_dec),
    .active_dec_i    (active_dec_i),
    .readyout_dec_i  (readyout_dec_i),
    .resp_dec_i      (resp_dec_i),
    .rdata_dec_i     (rdata_dec_i),
    .ruser_dec_i     (ruser_dec_i),
    .err_clr         (err_clr),
    .sel_dec_o       (sel_dec_o),
    .active_dec      (active_dec),
    .HREADYOUTS      (HREADYOUTS),
    .HRESPS          (HRESPS),
    .HRUSERS         (HRUSERS),
    .HRDATAS         (HRDATAS),
    .err_valid       (err_valid),
    .err_addr        (err_addr),
    .err_count       (err_count)
  );

  always #5 HCLK = ~HCLK;

  // Port-side values applied on the next driven cycle.
  logic [NP-1:0]     p_active;
  logic [NP-1:0]     p_ready;
  logic [2*NP-1:0]   p_resp;
  logic [32*NP-1:0]  p_rdata;
  logic [RW*NP-1:0]  p_ruser;

  int unsigned win_base  [NP] = '{32'h000000, 32'h080000};
  int unsigned win_limit [NP] = '{32'h07FFFF, 32'h1FFFFF};

  // Model state: data-phase owner, cycles into the error response
  // (0 none, 1 wait cycle, 2 completing cycle), and the error record.
  int          m_dp;
  int          m_ds;
  bit          m_valid;
  int unsigned m_addr;
  int          m_cnt;
  bit          m_known = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int region_of(input int unsigned a);
    for (int i = 0; i < NP; i++) begin
      if (a >= win_base[i] && a <= win_limit[i]) return i;
    end
    return DEF;
  endfunction

  function automatic bit model_ready();
    if (m_dp < NP) return p_ready[m_dp];
    return (m_ds != 1);
  endfunction

  task automatic rand_ports();
    p_active = NP'($urandom);
    p_ready  = NP'($urandom);
    p_resp   = (2*NP)'($urandom);
    p_rdata  = {$urandom, $urandom};
    p_ruser  = (RW*NP)'($urandom);
  endtask

  // One bus cycle: drive at negedge, check just after, advance model at posedge.
  task automatic cycle(input bit rst, input bit sel, input int unsigned a,
                       input logic [1:0] tr, input bit hr, input bit clr);
    int          tgt;
    bit          nacc;
    logic [NP-1:0] e_sel;
    logic        e_act;
    logic        e_rdy;
    logic [1:0]  e_resp;
    logic [31:0] e_data;
    logic [RW-1:0] e_user;
    @(negedge HCLK);
    HRESET          = rst;
    sel_dec         = sel;
    decode_addr_dec = a[AW-1:0];
    trans_dec       = tr;
    HREADYS         = hr;
    err_clr         = clr;
    active_dec_i    = p_active;
    readyout_dec_i  = p_ready;
    resp_dec_i      = p_resp;
    rdata_dec_i     = p_rdata;
    ruser_dec_i     = p_ruser;
    #1;
    tgt = region_of(a);
    if (tr == 2'b00 && m_known) tgt = m_dp;
    if (m_known) begin
      e_sel = '0;
      if (sel && tgt < NP) e_sel[tgt] = 1'b1;
      e_act = (tgt < NP) ? p_active[tgt] : 1'b1;
      if (m_dp < NP) begin
        e_rdy  = p_ready[m_dp];
        e_resp = p_resp[2*m_dp +: 2];
        e_data = p_rdata[32*m_dp +: 32];
        e_user = p_ruser[RW*m_dp +: RW];
      end else begin
        e_rdy  = (m_ds != 1);
        e_resp = (m_ds == 0) ? 2'b00 : 2'b01;
        e_data = '0;
        e_user = '0;
      end
      chk("sel_dec_o", 32'(sel_dec_o), 32'(e_sel));
      chk("active_dec", 32'(active_dec), 32'(e_act));
      chk("HREADYOUTS", 32'(HREADYOUTS), 32'(e_rdy));
      chk("HRESPS", 32'(HRESPS), 32'(e_resp));
      chk("HRDATAS", HRDATAS, e_data);
      chk("HRUSERS", 32'(HRUSERS), 32'(e_user));
      chk("err_valid", 32'(err_valid), 32'(m_valid));
      chk("err_addr", 32'(err_addr), m_addr);
      chk("err_count", 32'(err_count), 32'(m_cnt));
    end
    @(posedge HCLK);
    nacc = sel && (tgt == DEF) && hr && tr[1];
    if (rst) begin
      m_dp = DEF; m_ds = 0; m_valid = 1'b0; m_addr = 0; m_cnt = 0; m_known = 1'b1;
    end else begin
      m_ds = (m_ds == 1) ? 2 : (nacc ? 1 : 0);
      if (hr) m_dp = tgt;
      if (nacc) begin
        if (!m_valid || clr) m_addr = a;
        m_valid = 1'b1;
        m_cnt   = clr ? 1 : ((m_cnt == CMAX) ? CMAX : m_cnt + 1);
      end else if (clr) begin
        m_valid = 1'b0;
        m_cnt   = 0;
      end
    end
  endtask

  int unsigned edges [6] = '{32'h000000, 32'h07FFFF, 32'h080000, 32'h1FFFFF, 32'h200000, 32'h3FFFFF};

  initial begin
    int unsigned ra;
    bit          rhr;
    rand_ports();

    // Reset state
    cycle(1, 0, 0, 2'b00, 1, 0);
    cycle(1, 0, 0, 2'b00, 1, 0);
    #2;
    chk("rst_ready", 32'(HREADYOUTS), 32'h1);
    chk("rst_resp", 32'(HRESPS), 32'h0);
    chk("rst_rdata", HRDATAS, 32'h0);
    chk("rst_ruser", 32'(HRUSERS), 32'h0);
    chk("rst_count", 32'(err_count), 32'h0);

    // Decode to port1, data mux, 3-cycle stall
    p_ready = 2'b11;
    p_rdata[63:32] = 32'hA5A5_0001;
    cycle(0, 1, 32'h080000, 2'b10, 1, 0);
    #2;
    chk("t1_sel", 32'(sel_dec_o), 32'h2);
    chk("t1_rdata", HRDATAS, 32'hA5A5_0001);
    p_ready = 2'b01;
    repeat (3) begin
      cycle(0, 1, 32'h080004, 2'b00, 0, 0);
      #2;
      chk("t1_stall", 32'(HREADYOUTS), 32'h0);
    end
    p_ready = 2'b11;
    cycle(0, 1, 32'h080004, 2'b00, 1, 0);
    #2;
    chk("t1_done", 32'(HREADYOUTS), 32'h1);

    // Unmapped access
    cycle(0, 1, 32'h200000, 2'b10, 1, 0);
    #2;
    chk("t2_sel", 32'(sel_dec_o), 32'h0);
    chk("t2_rdy1", 32'(HREADYOUTS), 32'h0);
    chk("t2_resp1", 32'(HRESPS), 32'h1);
    chk("t2_valid", 32'(err_valid), 32'h1);
    chk("t2_addr", 32'(err_addr), 32'h200000);
    chk("t2_count", 32'(err_count), 32'h1);
    cycle(0, 1, 32'h200000, 2'b00, 0, 0);
    #2;
    chk("t2_rdy2", 32'(HREADYOUTS), 32'h1);
    chk("t2_resp2", 32'(HRESPS), 32'h1);
    cycle(0, 0, 0, 2'b00, 1, 0);
    #2;
    chk("t2_resp3", 32'(HRESPS), 32'h0);

    // Clear, then back-to-back unmapped NONSEQ
    cycle(0, 0, 0, 2'b00, 1, 1);
    #2;
    chk("t3_clr_valid", 32'(err_valid), 32'h0);
    chk("t3_clr_count", 32'(err_count), 32'h0);
    chk("t3_clr_addr", 32'(err_addr), 32'h200000);
    cycle(0, 1, 32'h300000, 2'b10, 1, 0);
    #2;
    chk("t3_err1a", 32'({HREADYOUTS, HRESPS}), 32'h1);
    cycle(0, 1, 32'h300001, 2'b10, 0, 0);
    #2;
    chk("t3_err2a", 32'({HREADYOUTS, HRESPS}), 32'h5);
    cycle(0, 1, 32'h300001, 2'b10, 1, 0);
    #2;
    chk("t3_err1b", 32'({HREADYOUTS, HRESPS}), 32'h1);
    chk("t3_addr", 32'(err_addr), 32'h300000);
    chk("t3_count", 32'(err_count), 32'h2);
    cycle(0, 0, 0, 2'b00, 0, 0);
    #2;
    chk("t3_err2b", 32'({HREADYOUTS, HRESPS}), 32'h5);
    cycle(0, 0, 0, 2'b00, 1, 0);
    #2;
    chk("t3_idle", 32'({HREADYOUTS, HRESPS}), 32'h4);

    // IDLE_HOLD keeps port1 while address points into port0
    p_rdata = {32'hBEEF_0004, 32'h1234_0000};
    cycle(0, 1, 32'h080010, 2'b10, 1, 0);
    cycle(0, 1, 32'h000010, 2'b00, 1, 0);
    #2;
    chk("t4_sel", 32'(sel_dec_o), 32'h2);
    chk("t4_rdata", HRDATAS, 32'hBEEF_0004);

    // Saturation, then clear colliding with a new error
    cycle(0, 0, 0, 2'b00, 1, 1);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 1, 32'h2F0000 + k, 2'b10, 1, 0);
      cycle(0, 0, 0, 2'b00, 0, 0);
    end
    #2;
    chk("t5_sat", 32'(err_count), 32'h3);
    cycle(0, 1, 32'h2ABCDE, 2'b10, 1, 1);
    #2;
    chk("t5_clr_count", 32'(err_count), 32'h1);
    chk("t5_clr_addr", 32'(err_addr), 32'h2ABCDE);
    chk("t5_clr_valid", 32'(err_valid), 32'h1);

    // Reset while in the wait cycle of an error response
    cycle(1, 0, 0, 2'b00, 0, 0);
    #2;
    chk("t6_ready", 32'(HREADYOUTS), 32'h1);
    chk("t6_resp", 32'(HRESPS), 32'h0);
    chk("t6_count", 32'(err_count), 32'h0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      rand_ports();
      if ($urandom_range(0, 3) == 0) ra = edges[$urandom_range(0, 5)];
      else ra = $urandom_range(0, 32'h3FFFFF);
      rhr = ($urandom_range(0, 3) != 0) ? model_ready() : 1'($urandom);
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) != 0), ra,
            2'($urandom), rhr, ($urandom_range(0, 19) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
